// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared register-file sizing for the scoreboard
package reg_scoreboard_pkg;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/status bundle for the scoreboard
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic            issue_valid;
  logic            issue_ready;
  logic [AW-1:0]   issue_rj;
  logic            issue_rj_en;
  logic [AW-1:0]   issue_rk;
  logic            issue_rk_en;
  logic [AW-1:0]   issue_rd;
  logic            issue_rd_en;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            flush;
  logic [NREG-1:0] busy_vec;
  logic            stall;
  logic            err;

  // Issue stage / writeback side drives requests and observes status.
  modport master (
    output issue_valid, issue_rj, issue_rj_en, issue_rk, issue_rk_en,
           issue_rd, issue_rd_en, wb_valid, wb_rd, flush,
    input  issue_ready, busy_vec, stall, err
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rj, issue_rj_en, issue_rk, issue_rk_en,
           issue_rd, issue_rd_en, wb_valid, wb_rd, flush,
    output issue_ready, busy_vec, stall, err
  );
endinterface

// File: rtl/reg_scoreboard_cnt.sv
// rtl/reg_scoreboard_cnt.sv - per-register pending-write up/down counter
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over inc/dec; inc and dec together cancel. Callers guarantee
  // no overflow (issue gating) and no underflow (dec gated on nonzero).
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && !i_dec)
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    else if (i_dec && !i_inc)
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/reg_scoreboard_dec.sv
// rtl/reg_scoreboard_dec.sv - 5->32 one-hot register address decoder
module decoder_5_32 (
  input  logic [4:0]  i_addr,
  input  logic        i_en,
  output logic [31:0] o_onehot
);
  // All-zero output when disabled so callers can AND it straight into masks.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot = 32'd1 << i_addr;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight register write tracker producing stall/busy
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int SB_CNT_W = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  reg_scoreboard_if.slave sb
);
  localparam logic [SB_CNT_W-1:0] LP_MAX = '1;

  logic [NREG-1:0]     w_rd_oh;
  logic [NREG-1:0]     w_wb_oh;
  logic [NREG-1:0]     w_rj_oh;
  logic [SB_CNT_W-1:0] w_cnt     [NREG];
  logic [SB_CNT_W-1:0] w_eff_cnt [NREG];
  logic [NREG-1:0]     w_dec;
  logic [NREG-1:0]     w_eff_nz;
  logic [NREG-1:0]     w_eff_max;
  logic [NREG-1:0]     w_busy;
  logic                w_hazard;
  logic                w_full;
  logic                w_ready;
  logic                w_fire;
  logic                w_wb_err;
  logic                r_err;

  // rd decode is not gated by fire: ready depends on it, fire depends on ready.
  decoder_5_32 u_dec_rd (.i_addr(sb.issue_rd), .i_en(sb.issue_rd_en), .o_onehot(w_rd_oh));
  decoder_5_32 u_dec_wb (.i_addr(sb.wb_rd),    .i_en(sb.wb_valid),    .o_onehot(w_wb_oh));
  decoder_5_32 u_dec_rj (.i_addr(sb.issue_rj), .i_en(sb.issue_rj_en), .o_onehot(w_rj_oh));

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_reg
      if (g == 0) begin : g_zero
        assign w_cnt[g] = '0;
      end else begin : g_cnt
        sb_counter #(.CNT_W(SB_CNT_W)) u_cnt (
          .clk   (clk),
          .rst   (rst),
          .i_inc (w_rd_oh[g] & w_fire),
          .i_dec (w_dec[g]),
          .i_clr (sb.flush),
          .o_cnt (w_cnt[g])
        );
      end
      // A same-cycle writeback already frees its slot for the issue checks.
      assign w_dec[g]     = w_wb_oh[g] & (w_cnt[g] != '0);
      assign w_eff_cnt[g] = w_cnt[g] - {{(SB_CNT_W-1){1'b0}}, w_dec[g]};
      assign w_eff_nz[g]  = (w_eff_cnt[g] != '0);
      assign w_eff_max[g] = (w_eff_cnt[g] == LP_MAX);
      assign w_busy[g]    = (w_cnt[g] != '0);
    end
  endgenerate

  // r0 never has a count, so its lookups are always clear.
  assign w_hazard = (|(w_rj_oh & w_eff_nz)) |
                    (sb.issue_rk_en & (sb.issue_rk != REG_ZERO) & w_eff_nz[sb.issue_rk]);
  assign w_full   = |(w_rd_oh & w_eff_max);
  assign w_ready  = ~sb.flush & ~w_hazard & ~w_full;
  assign w_fire   = sb.issue_valid & w_ready;

  // Writeback to an idle non-zero register is a protocol error.
  assign w_wb_err = ~sb.flush & (|(w_wb_oh[NREG-1:1] & ~w_busy[NREG-1:1]));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_wb_err)
      r_err <= 1'b1;
  end

  assign sb.issue_ready = w_ready;
  assign sb.stall       = sb.issue_valid & ~w_ready;
  assign sb.busy_vec    = w_busy;
  assign sb.err         = r_err;
endmodule
